// File: rtl/secded_decode_seq.sv
// SECDED decode sequencer: reads Hamming(16,11) codewords from data memory, corrects or
// flags them, and writes 11-bit payload plus 2-bit error flag back to a destination area.
module secded_decode_seq #(
  parameter int unsigned NUM_WORDS = 15,
  parameter int unsigned SRC_BASE  = 30,
  parameter int unsigned DST_BASE  = 0,
  parameter int unsigned AW        = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic [3:0]    single_cnt,
  output logic [3:0]    double_cnt
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned DAT_W = 11;
  localparam logic [AW-1:0]    SRC_A    = AW'(SRC_BASE);
  localparam logic [AW-1:0]    DST_A    = AW'(DST_BASE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_DEC,
    S_WR_LO,
    S_WR_HI,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         lo_q, lo_d;
  logic [7:0]         hi_q, hi_d;
  logic [DAT_W-1:0]   data_q, data_d;
  logic [1:0]         flag_q, flag_d;
  logic [3:0]         single_cnt_q, single_cnt_d;
  logic [3:0]         double_cnt_q, double_cnt_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [AW-1:0]      mem_addr_q, mem_addr_d;
  logic               mem_we_q, mem_we_d;
  logic [7:0]         mem_wdata_q, mem_wdata_d;

  logic [15:0]        cw_c;
  logic [15:0]        fix_c;
  logic [3:0]         syn_c;
  logic               par_c;
  logic [1:0]         flag_c;
  logic [DAT_W-1:0]   data_c;

  // Byte address of the low (hi=0) or high (hi=1) half of word idx in an area.
  function automatic logic [AW-1:0] word_addr(input logic [AW-1:0] base,
                                              input logic [IDX_W-1:0] idx,
                                              input logic hi);
    return base + AW'({idx, 1'b0}) + AW'(hi);
  endfunction

  // Syndrome is the XOR of set-bit positions; overall parity separates single from double.
  always_comb begin
    cw_c  = {hi_q, lo_q};
    syn_c = '0;
    for (int k = 1; k < 16; k++) begin
      if (cw_c[k]) syn_c = syn_c ^ 4'(k);
    end
    par_c = ^cw_c;
    fix_c = cw_c;
    if (par_c) fix_c[syn_c] = ~cw_c[syn_c];
    if (par_c)              flag_c = 2'b01;
    else if (syn_c != 4'd0) flag_c = 2'b10;
    else                    flag_c = 2'b00;
    data_c = {fix_c[15:9], fix_c[7:5], fix_c[3]};
  end

  // Next-state and datapath; outputs are then decoded from the next state so they register.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    data_d       = data_q;
    flag_d       = flag_q;
    single_cnt_d = single_cnt_q;
    double_cnt_d = double_cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_RD_LO;
          idx_d        = '0;
          single_cnt_d = '0;
          double_cnt_d = '0;
        end
      end
      S_RD_LO: begin
        lo_d    = mem_rdata;
        state_d = S_RD_HI;
      end
      S_RD_HI: begin
        hi_d    = mem_rdata;
        state_d = S_DEC;
      end
      S_DEC: begin
        data_d = data_c;
        flag_d = flag_c;
        if (flag_c == 2'b01) single_cnt_d = single_cnt_q + 4'd1;
        if (flag_c == 2'b10) double_cnt_d = double_cnt_q + 4'd1;
        state_d = S_WR_LO;
      end
      S_WR_LO: begin
        state_d = S_WR_HI;
      end
      S_WR_HI: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_RD_LO;
        end
      end
      default: state_d = S_IDLE;
    endcase

    unique case (state_d)
      S_RD_LO: mem_addr_d = word_addr(SRC_A, idx_d, 1'b0);
      S_RD_HI: mem_addr_d = word_addr(SRC_A, idx_d, 1'b1);
      S_WR_LO: begin
        mem_addr_d  = word_addr(DST_A, idx_d, 1'b0);
        mem_we_d    = 1'b1;
        mem_wdata_d = data_d[7:0];
      end
      S_WR_HI: begin
        mem_addr_d  = word_addr(DST_A, idx_d, 1'b1);
        mem_we_d    = 1'b1;
        mem_wdata_d = {flag_d, 3'b000, data_d[10:8]};
      end
      default: ;
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    // done follows one cycle behind entry to DONE and clears as soon as a restart is taken.
    done_d = (state_q == S_DONE) && (state_d == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
      data_q       <= '0;
      flag_q       <= '0;
      single_cnt_q <= '0;
      double_cnt_q <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      data_q       <= data_d;
      flag_q       <= flag_d;
      single_cnt_q <= single_cnt_d;
      double_cnt_q <= double_cnt_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign done       = done_q;
  assign busy       = busy_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign single_cnt = single_cnt_q;
  assign double_cnt = double_cnt_q;

endmodule

// File: tb/tb_secded_decode_seq.sv
// Bench for secded_decode_seq: byte memory model, parity-group decode model and a
// per-cycle compare of every output against the expected run timeline.
module tb_secded_decode_seq;

  localparam int NW  = 15;
  localparam int SRC = 30;
  localparam int DST = 0;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       done, busy, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] single_cnt, double_cnt;

  logic [7:0] mem [256];
  logic       ld_we = 1'b0;
  logic [7:0] ld_addr = '0;
  logic [7:0] ld_data = '0;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] cws [NW];
  logic [1:0]  e_flag [NW];
  logic [10:0] e_data [NW];
  int          cum_s [NW+1];
  int          cum_d [NW+1];

  logic track = 1'b0;
  int   t = 0;
  int   t_end = 0;
  int   w, ph, es, ed;

  secded_decode_seq #(.NUM_WORDS(NW), .SRC_BASE(SRC), .DST_BASE(DST), .AW(8)) dut (
    .clock(clock), .reset(reset), .start(start), .done(done), .busy(busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .single_cnt(single_cnt), .double_cnt(double_cnt)
  );

  always #5 clock = ~clock;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clock) begin
    if (mem_we)     mem[mem_addr] <= mem_wdata;
    else if (ld_we) mem[ld_addr]  <= ld_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", name, act, exp, t, $time);
    end
  endtask

  // Decode via the textbook parity groups; data bits are the non-power-of-two positions.
  function automatic logic [12:0] model_decode(input logic [15:0] cw);
    logic [3:0]  s;
    logic        p;
    logic [15:0] c;
    logic [10:0] d;
    logic [1:0]  f;
    int          j;
    s = '0;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 16; k++)
        if ((k & (1 << i)) != 0) s[i] = s[i] ^ cw[k];
    p = ^cw;
    c = cw;
    if (p) c[s] = ~c[s];
    f = p ? 2'b01 : ((s != 0) ? 2'b10 : 2'b00);
    d = '0;
    j = 0;
    for (int k = 1; k < 16; k++)
      if ((k & (k - 1)) != 0) begin
        d[j] = c[k];
        j++;
      end
    return {f, d};
  endfunction

  task automatic load_byte(input int a, input logic [7:0] v);
    ld_addr = 8'(a);
    ld_data = v;
    ld_we   = 1'b1;
    @(posedge clock);
    #1 ld_we = 1'b0;
  endtask

  task automatic prepare_run();
    logic [12:0] r;
    cum_s[0] = 0;
    cum_d[0] = 0;
    for (int i = 0; i < NW; i++) begin
      load_byte(SRC + 2 * i, cws[i][7:0]);
      load_byte(SRC + 2 * i + 1, cws[i][15:8]);
      r = model_decode(cws[i]);
      e_flag[i]  = r[12:11];
      e_data[i]  = r[10:0];
      cum_s[i+1] = cum_s[i] + ((r[12:11] == 2'b01) ? 1 : 0);
      cum_d[i+1] = cum_d[i] + ((r[12:11] == 2'b10) ? 1 : 0);
    end
  endtask

  task automatic launch(input int tend);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    t     = 0;
    t_end = tend;
    track = 1'b1;
  endtask

  task automatic check_written(input int nwords);
    for (int i = 0; i < nwords; i++) begin
      chk($sformatf("mem_lo[%0d]", i), 32'(mem[DST + 2 * i]), 32'(e_data[i][7:0]));
      chk($sformatf("mem_hi[%0d]", i), 32'(mem[DST + 2 * i + 1]),
          32'({e_flag[i], 3'b000, e_data[i][10:8]}));
    end
  endtask

  // Expected outputs as a function of cycles since the accepted start: 5 cycles per word.
  always @(negedge clock) begin
    if (track && t < t_end) begin
      if (t < 5 * NW) begin
        w  = t / 5;
        ph = t % 5;
        es = cum_s[w] + ((ph >= 3 && e_flag[w] == 2'b01) ? 1 : 0);
        ed = cum_d[w] + ((ph >= 3 && e_flag[w] == 2'b10) ? 1 : 0);
        chk("busy", 32'(busy), 32'(1));
        chk("done", 32'(done), 32'(0));
        chk("mem_we", 32'(mem_we), 32'(ph >= 3));
        case (ph)
          0: chk("rd_lo_addr", 32'(mem_addr), 32'(SRC + 2 * w));
          1: chk("rd_hi_addr", 32'(mem_addr), 32'(SRC + 2 * w + 1));
          3: begin
            chk("wr_lo_addr", 32'(mem_addr), 32'(DST + 2 * w));
            chk("wr_lo_data", 32'(mem_wdata), 32'(e_data[w][7:0]));
          end
          4: begin
            chk("wr_hi_addr", 32'(mem_addr), 32'(DST + 2 * w + 1));
            chk("wr_hi_data", 32'(mem_wdata), 32'({e_flag[w], 3'b000, e_data[w][10:8]}));
          end
          default: ;
        endcase
      end else begin
        es = cum_s[NW];
        ed = cum_d[NW];
        chk("busy_end", 32'(busy), 32'(0));
        chk("mem_we_end", 32'(mem_we), 32'(0));
        chk("done_end", 32'(done), 32'(t >= 5 * NW + 1));
      end
      chk("single_cnt", 32'(single_cnt), 32'(es));
      chk("double_cnt", 32'(double_cnt), 32'(ed));
    end
    if (track) t++;
  end

  initial begin
    // Model pinned against hand-decoded codewords.
    chk("model_0000", 32'(model_decode(16'h0000)), 32'({2'b00, 11'h000}));
    chk("model_0020", 32'(model_decode(16'h0020)), 32'({2'b01, 11'h000}));
    chk("model_7fff", 32'(model_decode(16'h7FFF)), 32'({2'b01, 11'h7FF}));
    chk("model_0028", 32'(model_decode(16'h0028)), 32'({2'b10, 11'h003}));
    chk("model_0001", 32'(model_decode(16'h0001)), 32'({2'b01, 11'h000}));

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_we", 32'(mem_we), 32'(0));
    chk("rst_addr", 32'(mem_addr), 32'(0));
    chk("rst_wdata", 32'(mem_wdata), 32'(0));
    chk("rst_cnts", 32'({single_cnt, double_cnt}), 32'(0));

    // Run 1: directed vectors in words 0..4, random remainder.
    cws[0] = 16'h0000;
    cws[1] = 16'h0020;
    cws[2] = 16'h7FFF;
    cws[3] = 16'h0028;
    cws[4] = 16'h0001;
    for (int i = 5; i < NW; i++) cws[i] = 16'($urandom_range(0, 65535));
    prepare_run();
    launch(80);
    repeat (81) @(posedge clock);
    #1 track = 1'b0;
    check_written(NW);
    chk("lit_mem0", 32'(mem[0]), 32'h00);
    chk("lit_mem1", 32'(mem[1]), 32'h00);
    chk("lit_mem3", 32'(mem[3]), 32'h40);
    chk("lit_mem4", 32'(mem[4]), 32'hFF);
    chk("lit_mem5", 32'(mem[5]), 32'h47);
    chk("lit_mem6", 32'(mem[6]), 32'h03);
    chk("lit_mem7", 32'(mem[7]), 32'h80);
    chk("lit_mem9", 32'(mem[9]), 32'h40);
    @(negedge clock);
    chk("done_hold", 32'(done), 32'(1));

    // Run 2: random words, restart from DONE, start re-pulsed mid-run.
    for (int i = 0; i < NW; i++) cws[i] = 16'($urandom_range(0, 65535));
    cws[7] = 16'h0C00;
    prepare_run();
    launch(80);
    repeat (19) @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (61) @(posedge clock);
    #1 track = 1'b0;
    check_written(NW);

    // Run 3: reset during DEC of word 3 aborts before word 3 is written.
    for (int i = 0; i < 2 * NW; i++) load_byte(DST + i, 8'hAA);
    for (int i = 0; i < NW; i++) cws[i] = 16'($urandom_range(0, 65535));
    prepare_run();
    launch(18);
    repeat (17) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    track = 1'b0;
    @(negedge clock);
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_we", 32'(mem_we), 32'(0));
    chk("abort_cnts", 32'({single_cnt, double_cnt}), 32'(0));
    repeat (10) @(posedge clock);
    @(negedge clock);
    chk("abort_idle_done", 32'(done), 32'(0));
    chk("abort_idle_we", 32'(mem_we), 32'(0));
    check_written(3);
    chk("abort_w3_lo", 32'(mem[DST + 6]), 32'hAA);
    chk("abort_w3_hi", 32'(mem[DST + 7]), 32'hAA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
